// File: rtl/scramble_generator_if.sv
// Request/abort controls and the valid/ready move stream between the scramble
// generator (master) and the controller plus puzzle-state consumer (slave).
interface scramble_generator_if;
    logic       RandomPlease;
    logic       abort;
    logic       move_ready;
    logic       move_valid;
    logic [2:0] move_code;
    logic       busy;
    logic       done;

    modport master (
        input  RandomPlease,
        input  abort,
        input  move_ready,
        output move_valid,
        output move_code,
        output busy,
        output done
    );

    modport slave (
        output RandomPlease,
        output abort,
        output move_ready,
        input  move_valid,
        input  move_code,
        input  busy,
        input  done
    );
endinterface

// File: rtl/scramble_generator.sv
// Issues RandNum pseudo-random cube moves per request over a valid/ready stream,
// never emitting a move that immediately undoes the previous one.
module scramble_generator #(
    parameter int unsigned RandNum = 31,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    scramble_generator_if.master  bus
);

    localparam logic [15:0] LfsrInit   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LfsrMask   = 16'hB400;
    localparam logic [7:0]  MovesTotal = 8'(RandNum);
    localparam logic [2:0]  PrevNone   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        PRESENT,
        DONE
    } state_t;

    state_t      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [7:0]  count_q;
    logic [2:0]  prev_q;
    logic        rp_prev_q;
    logic        valid_q;
    logic [2:0]  code_q;
    logic        done_q;

    logic [2:0]  cand;
    logic        cand_ok;
    logic        req_rise;

    // Free-running Galois LFSR; it runs in every state so request timing adds entropy.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
    end

    // "None" (7) can never match a flipped legal candidate, so the first move is unrestricted.
    assign cand     = lfsr_q[2:0];
    assign cand_ok  = (cand < 3'd6) && ((cand ^ 3'd1) != prev_q);
    assign req_rise = bus.RandomPlease && !rp_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= LfsrInit;
            count_q   <= 8'd0;
            prev_q    <= PrevNone;
            rp_prev_q <= 1'b0;
            valid_q   <= 1'b0;
            code_q    <= 3'd0;
            done_q    <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            rp_prev_q <= bus.RandomPlease;
            done_q    <= 1'b0;
            if (state_q == IDLE) begin
                if (req_rise && !bus.abort) begin
                    state_q <= GEN;
                    count_q <= 8'd0;
                    prev_q  <= PrevNone;
                end
            end else if (bus.abort) begin
                // Abort discards everything, including a handshake landing on this edge.
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    GEN: begin
                        if (cand_ok) begin
                            code_q  <= cand;
                            valid_q <= 1'b1;
                            state_q <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (bus.move_ready) begin
                            count_q <= count_q + 8'd1;
                            prev_q  <= code_q;
                            valid_q <= 1'b0;
                            if (count_q + 8'd1 == MovesTotal) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= GEN;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.move_valid = valid_q;
    assign bus.move_code  = code_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_scramble_generator.sv
// Randomised bench for two scramble generators (RandNum=4 default seed, RandNum=31 seed 0)
// checked every cycle against a transaction-level model of the move stream.
module tb_scramble_generator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scramble_generator_if bus4 ();
    scramble_generator_if bus31 ();

    scramble_generator #(.RandNum(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    scramble_generator #(.RandNum(31), .SEED(16'h0000)) dut31 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus31)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Model: "live" = a request is outstanding (busy), "valid/code" = presented move.
    typedef struct {
        bit          live;
        bit          valid;
        logic [2:0]  code;
        int          count;
        int          prev;
        bit          done;
        bit          rp_prev;
        logic [15:0] lf;
    } mdl_t;

    mdl_t        m [2];
    int          nmoves [2] = '{4, 31};
    logic [15:0] seedv [2]  = '{16'hACE1, 16'h0001};

    int  hs_cnt [2]    = '{0, 0};
    int  done_cnt [2]  = '{0, 0};
    int  last_hs [2]   = '{7, 7};
    bit  prev_busy [2] = '{0, 0};
    bit  prev_done [2] = '{0, 0};
    bit  held_valid [2] = '{0, 0};
    logic [2:0] held_code [2];
    int  mode [2] = '{0, 0};

    function automatic void mdl_reset(input int i);
        m[i].live    = 1'b0;
        m[i].valid   = 1'b0;
        m[i].code    = 3'd0;
        m[i].count   = 0;
        m[i].prev    = 7;
        m[i].done    = 1'b0;
        m[i].rp_prev = 1'b0;
        m[i].lf      = seedv[i];
    endfunction

    function automatic void mdl_step(input int i, input bit rp, input bit ab, input bit rdy);
        logic [2:0] cand;
        cand = m[i].lf[2:0];
        if (!m[i].live) begin
            if (rp && !m[i].rp_prev && !ab) begin
                m[i].live  = 1'b1;
                m[i].count = 0;
                m[i].prev  = 7;
            end
        end else if (m[i].done) begin
            m[i].live = 1'b0;
            m[i].done = 1'b0;
        end else if (ab) begin
            m[i].live  = 1'b0;
            m[i].valid = 1'b0;
        end else if (m[i].valid) begin
            if (rdy) begin
                m[i].count++;
                m[i].prev  = int'(m[i].code);
                m[i].valid = 1'b0;
                if (m[i].count == nmoves[i]) m[i].done = 1'b1;
            end
        end else if (cand < 3'd6 && int'(cand ^ 3'd1) != m[i].prev) begin
            m[i].valid = 1'b1;
            m[i].code  = cand;
        end
        m[i].rp_prev = rp;
        m[i].lf      = lfsr_next(m[i].lf);
    endfunction

    task automatic mon_cmp(input int i, input logic v, input logic [2:0] c, input logic b,
                           input logic d, input logic rp, input logic ab, input logic rdy,
                           input logic [15:0] lf);
        string tag;
        tag = (i == 0) ? "n4" : "n31";
        check({tag, "_valid"}, int'(v), int'(m[i].valid));
        if (m[i].valid) check({tag, "_code"}, int'(c), int'(m[i].code));
        check({tag, "_busy"}, int'(b), int'(m[i].live));
        check({tag, "_done"}, int'(d), int'(m[i].done));
        check({tag, "_lfsr"}, int'(lf), int'(m[i].lf));
        if (b && !prev_busy[i]) last_hs[i] = 7;
        prev_busy[i] = b;
        if (held_valid[i] && v) check({tag, "_code_stable"}, int'(c), int'(held_code[i]));
        held_valid[i] = v && !rdy;
        held_code[i]  = c;
        if (v && rdy && !ab && rst_n) begin
            hs_cnt[i]++;
            check({tag, "_code_range"}, int'(c <= 3'd5), 1);
            check({tag, "_no_inverse"}, int'(int'(c ^ 3'd1) == last_hs[i]), 0);
            last_hs[i] = int'(c);
        end
        if (d) begin
            done_cnt[i]++;
            check({tag, "_done_single"}, int'(prev_done[i]), 0);
        end
        prev_done[i] = d;
        if (rst_n) mdl_step(i, rp, ab, rdy);
    endtask

    // Per-cycle comparison on the falling edge, then the model advances past the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mdl_reset(0);
                mdl_reset(1);
            end
            mon_cmp(0, bus4.move_valid, bus4.move_code, bus4.busy, bus4.done,
                    bus4.RandomPlease, bus4.abort, bus4.move_ready, dut4.lfsr_q);
            mon_cmp(1, bus31.move_valid, bus31.move_code, bus31.busy, bus31.done,
                    bus31.RandomPlease, bus31.abort, bus31.move_ready, dut31.lfsr_q);
        end
    end

    // Ready policies: 0 always, 1 low for the first 3 valid cycles, 2 random, 3 never.
    initial begin
        int   vcnt [2];
        logic vv;
        logic r;
        vcnt = '{0, 0};
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                vv = (i == 0) ? bus4.move_valid : bus31.move_valid;
                vcnt[i] = vv ? vcnt[i] + 1 : 0;
                case (mode[i])
                    0:       r = 1'b1;
                    1:       r = (vcnt[i] > 3);
                    2:       r = 1'($urandom_range(0, 1));
                    default: r = 1'b0;
                endcase
                if (i == 0) bus4.move_ready = r;
                else        bus31.move_ready = r;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rp(input int i, input logic v);
        if (i == 0) bus4.RandomPlease = v;
        else        bus31.RandomPlease = v;
    endtask

    task automatic set_ab(input int i, input logic v);
        if (i == 0) bus4.abort = v;
        else        bus31.abort = v;
    endtask

    function automatic logic busy_of(input int i);
        return (i == 0) ? bus4.busy : bus31.busy;
    endfunction

    task automatic pulse_req(input int i);
        set_rp(i, 1'b1);
        tick(1);
        set_rp(i, 1'b0);
    endtask

    task automatic wait_done(input int i, input int budget, input string name);
        int start;
        int k;
        start = done_cnt[i];
        k = 0;
        while (done_cnt[i] == start && k < budget) begin
            tick(1);
            k++;
        end
        check({name, "_done_seen"}, int'(done_cnt[i] > start), 1);
    endtask

    task automatic wait_idle(input int i, input int budget, input string name);
        int k;
        k = 0;
        while (busy_of(i) && k < budget) begin
            tick(1);
            k++;
        end
        check({name, "_idle_reached"}, int'(busy_of(i)), 0);
    endtask

    initial begin
        int          h0;
        int          d0;
        int          k;
        int          n;
        int          first_one;
        int          zero_seen;
        int          bad_valid;
        logic [15:0] v;

        rst_n = 1'b0;
        bus4.RandomPlease = 1'b0;  bus4.abort = 1'b0;  bus4.move_ready = 1'b0;
        bus31.RandomPlease = 1'b0; bus31.abort = 1'b0; bus31.move_ready = 1'b0;

        // Hand-computed pins on the model's LFSR.
        check("model_lfsr_step1", int'(lfsr_next(16'hACE1)), int'(16'hE270));
        check("model_lfsr_step2", int'(lfsr_next(lfsr_next(16'hACE1))), int'(16'h7138));
        v = 16'h0001;
        n = 0;
        do begin
            v = lfsr_next(v);
            n++;
        end while (v != 16'h0001 && n < 70000);
        check("model_lfsr_period", n, 65535);

        tick(3);
        check("rst_n4_busy", int'(bus4.busy), 0);
        check("rst_n4_valid", int'(bus4.move_valid), 0);
        check("rst_n4_code", int'(bus4.move_code), 0);
        check("rst_n4_done", int'(bus4.done), 0);
        check("rst_n4_lfsr", int'(dut4.lfsr_q), int'(16'hACE1));
        check("rst_n31_lfsr_seed0", int'(dut31.lfsr_q), 1);
        #1 rst_n = 1'b1;
        tick(2);

        // Four moves with ready held high.
        mode[0] = 0;
        h0 = hs_cnt[0]; d0 = done_cnt[0];
        pulse_req(0);
        wait_done(0, 300, "s4");
        check("s4_handshakes", hs_cnt[0] - h0, 4);
        check("s4_done_count", done_cnt[0] - d0, 1);
        check("s4_busy_after", int'(bus4.busy), 0);
        $display("txn: n4 scramble complete, handshakes=%0d", hs_cnt[0] - h0);

        // 31 moves with 3 not-ready cycles per move.
        mode[1] = 1;
        h0 = hs_cnt[1]; d0 = done_cnt[1];
        pulse_req(1);
        wait_done(1, 4000, "s31slow");
        tick(1);
        check("s31slow_handshakes", hs_cnt[1] - h0, 31);
        check("s31slow_done_count", done_cnt[1] - d0, 1);
        $display("txn: n31 slow-ready scramble complete, handshakes=%0d", hs_cnt[1] - h0);

        // Abort after the second handshake, then a full fresh scramble.
        mode[1] = 0;
        h0 = hs_cnt[1]; d0 = done_cnt[1];
        pulse_req(1);
        k = 0;
        while (hs_cnt[1] - h0 < 2 && k < 200) begin
            tick(1);
            k++;
        end
        check("abort_reached_2", hs_cnt[1] - h0, 2);
        set_ab(1, 1'b1);
        tick(1);
        set_ab(1, 1'b0);
        check("abort_busy", int'(bus31.busy), 0);
        check("abort_valid", int'(bus31.move_valid), 0);
        tick(5);
        check("abort_no_done", done_cnt[1] - d0, 0);
        check("abort_hs_kept", hs_cnt[1] - h0, 2);
        $display("txn: n31 aborted after %0d handshakes", hs_cnt[1] - h0);
        h0 = hs_cnt[1];
        pulse_req(1);
        wait_done(1, 2000, "after_abort");
        tick(1);
        check("after_abort_handshakes", hs_cnt[1] - h0, 31);
        check("after_abort_done_count", done_cnt[1] - d0, 1);

        // Held level gives one scramble; an edge while busy is dropped.
        mode[0] = 2;
        h0 = hs_cnt[0]; d0 = done_cnt[0];
        set_rp(0, 1'b1);
        tick(200);
        set_rp(0, 1'b0);
        tick(100);
        check("held_handshakes", hs_cnt[0] - h0, 4);
        check("held_done_count", done_cnt[0] - d0, 1);
        h0 = hs_cnt[0]; d0 = done_cnt[0];
        pulse_req(0);
        tick(2);
        check("busy_edge_is_busy", int'(bus4.busy), 1);
        pulse_req(0);
        tick(200);
        check("busy_edge_handshakes", hs_cnt[0] - h0, 4);
        check("busy_edge_done_count", done_cnt[0] - d0, 1);
        $display("txn: n4 held/busy-edge requests, handshakes=%0d", hs_cnt[0] - h0);

        // Randomised requests, random ready, random aborts.
        for (int it = 0; it < 30; it++) begin
            int i;
            i = int'($urandom_range(0, 1));
            mode[i] = 2;
            if ($urandom_range(0, 3) == 0) begin
                set_rp(i, 1'b1);
                set_ab(i, 1'b1);
                tick(1);
                set_ab(i, 1'b0);
                set_rp(i, 1'b0);
                tick(1);
                check("abort_wins_idle", int'(busy_of(i)), 0);
            end
            h0 = hs_cnt[i];
            set_rp(i, 1'b1);
            tick(int'($urandom_range(1, 3)));
            set_rp(i, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                tick(int'($urandom_range(0, 40)));
                set_ab(i, 1'b1);
                tick(1);
                set_ab(i, 1'b0);
            end
            wait_idle(i, 3000, "rand");
            tick(1);
            $display("txn: random it=%0d inst=%0d handshakes=%0d", it, i, hs_cnt[i] - h0);
        end

        // Asynchronous reset while a move is presented.
        mode[1] = 3;
        pulse_req(1);
        k = 0;
        while (!bus31.move_valid && k < 100) begin
            tick(1);
            k++;
        end
        check("present_reached", int'(bus31.move_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(bus31.move_valid), 0);
        check("async_rst_busy", int'(bus31.busy), 0);
        check("async_rst_code", int'(bus31.move_code), 0);
        check("async_rst_done", int'(bus31.done), 0);
        check("async_rst_lfsr", int'(dut31.lfsr_q), 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        mode[1] = 0;
        $display("txn: n31 reset during present");

        // LFSR period and no-zero over 70000 cycles from reset release.
        first_one = 0;
        zero_seen = 0;
        bad_valid = 0;
        for (int j = 1; j <= 70000; j++) begin
            tick(1);
            if (dut31.lfsr_q == 16'h0000) zero_seen++;
            if (dut31.lfsr_q == 16'h0001 && first_one == 0) first_one = j;
            if (j <= 20 && bus31.move_valid) bad_valid++;
        end
        check("post_reset_no_valid", bad_valid, 0);
        check("dut_lfsr_never_zero", zero_seen, 0);
        check("dut_lfsr_period", first_one, 65535);
        $display("txn: n31 lfsr period=%0d zeros=%0d", first_one, zero_seen);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scramble_generator.md
SCRAMBLE_GENERATOR -- requirements
Module: scramble_generator

Interface
REQ-001 Parameter RandNum, default 31: number of scramble moves issued per request; legal range 1..255.
REQ-002 Parameter SEED, default 16'hACE1: LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 RandomPlease  input  1  scramble request from the shuffle/solve controller; level signal, sampled synchronously.
REQ-006 abort  input  1  cancel the scramble in progress (controller left mix state).
REQ-007 move_ready  input  1  downstream puzzle-state block accepts the presented move.
REQ-008 move_valid  output  1  move_code is valid and held stable until accepted.
REQ-009 move_code  output  3  move identifier 0..5; pairs {0,1}, {2,3} and {4,5} are mutual inverses.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after the final move is accepted.

Function
REQ-012 The block SHALL contain a 16-bit Galois LFSR with feedback mask 16'hB400 (shift right, XOR the mask when bit0=1), advancing every clock in all states so that request timing provides entropy.
REQ-013 The LFSR SHALL never reach 0.
REQ-014 FSM states SHALL be IDLE, GEN, PRESENT and DONE.
REQ-015 IDLE: on a rising edge of RandomPlease (registered previous value 0, current value 1) with abort=0 -> GEN; clear the move counter; set the previous-move register to "none".
REQ-016 A level held high SHALL NOT retrigger; a new request requires RandomPlease to return low first.
REQ-017 GEN: candidate = lfsr[2:0]; the candidate SHALL be rejected (stay in GEN, retry next cycle) if it is >= 6, or if (candidate XOR 1) equals the previous move.
REQ-018 GEN accept: latch the candidate into move_code, assert move_valid, -> PRESENT; an accept SHALL cost exactly 1 cycle beyond rejections.
REQ-019 PRESENT: move_valid=1 and move_code stable; a handshake occurs when move_valid and move_ready are both 1 on a clock edge.
REQ-020 On handshake: counter += 1, previous move <= move_code, move_valid <= 0; if the new count == RandNum -> DONE, else -> GEN.
REQ-021 The counter width SHALL be 8 bits, and the counter SHALL never exceed RandNum.
REQ-022 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-023 RandomPlease edges while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 abort=1 in any non-IDLE state -> IDLE next edge; move_valid cleared; done SHALL NOT pulse; a handshake in that same cycle is discarded (counter not incremented).
REQ-025 Simultaneous abort and RandomPlease rising edge in IDLE: abort wins and the block stays in IDLE.
REQ-026 Moves issued after abort belong to the next request only; no partial state is carried over.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, move_valid=0, move_code=0, busy=0, done=0, counter=0, previous move "none", LFSR=SEED (or 1 if SEED is 0), request-edge register=0.
REQ-028 Reset asserted mid-scramble SHALL discard the scramble with no done pulse; release SHALL be synchronous to clk.

Verification
REQ-029 RandNum=4, move_ready=1, 1-cycle RandomPlease pulse -> exactly 4 handshakes, all codes in 0..5, no consecutive inverse pair, done high exactly 1 cycle, then busy=0.
REQ-030 RandNum=31, move_ready low 3 cycles per move -> move_code stable while valid and not ready; 31 handshakes; single done.
REQ-031 abort=1 after 2nd handshake of 31 -> busy=0 next cycle, move_valid=0, no done; next request yields a full 31 moves.
REQ-032 RandomPlease held high 200 cycles -> exactly one scramble; second pulse during busy -> ignored (still exactly RandNum moves total).
REQ-033 SEED=0 -> LFSR reset value 1; LFSR never 0 over 70000 cycles and period = 65535.
REQ-034 rst_n low during PRESENT -> all outputs 0 asynchronously (before the next clk edge); after release, no move_valid until a new request.
